// File: rtl/exc_ctrl_if.sv
// Pipeline <-> exception sequencer bundle: fault requests in, special-register
// write strobes, privilege, and fetch redirect out.
interface exc_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic            exc_if_valid;
   logic [XLEN-1:0] exc_if_pc;
   logic            exc_id_valid;
   logic [XLEN-1:0] exc_id_pc;
   logic            exc_mem_valid;
   logic [XLEN-1:0] exc_mem_pc;
   logic [XLEN-1:0] exc_mem_addr;
   logic            iret_req;
   logic [XLEN-1:0] rm0_in;

   logic [XLEN-1:0]  sr_rm0;
   logic [XLEN-1:0]  sr_rm1;
   logic [XLEN-1:0]  sr_rm2;
   logic             priv;
   logic             flush;
   logic             stall;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             busy;
   logic [CNT_W-1:0] exc_count;

   modport master (
      output exc_if_valid, exc_if_pc, exc_id_valid, exc_id_pc,
             exc_mem_valid, exc_mem_pc, exc_mem_addr, iret_req, rm0_in,
      input  sr_rm0, sr_rm1, sr_rm2, priv, flush, stall,
             redirect_valid, redirect_pc, busy, exc_count
   );

   modport slave (
      input  exc_if_valid, exc_if_pc, exc_id_valid, exc_id_pc,
             exc_mem_valid, exc_mem_pc, exc_mem_addr, iret_req, rm0_in,
      output sr_rm0, sr_rm1, sr_rm2, priv, flush, stall,
             redirect_valid, redirect_pc, busy, exc_count
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/trap sequencer: arbitrates IF/ID/MEM faults and iret, flushes the
// pipeline, commits the exception record in one save pulse, redirects fetch.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | pipeline running, requests sampled
//   FLUSH    | kill in-flight instructions, FLUSH_CYCLES cycles
//   SAVE     | single-cycle commit of rm0/rm1/rm2
//   REDIRECT | fetch from HANDLER_PC, enter supervisor
//   IRET     | fetch from rm0, drop to user
module exc_ctrl #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] HANDLER_PC   = 32'h0000_2000,
   parameter int              FLUSH_CYCLES = 2,
   parameter int              CNT_W        = 16
) (
   input logic       clk,
   input logic       reset,
   exc_ctrl_if.slave ctl
);
   typedef enum logic [2:0] {IDLE, FLUSH, SAVE, REDIRECT, IRET} state_t;

   state_t           state;
   logic [3:0]       flush_cnt;
   logic [XLEN-1:0]  pc_q, addr_q;
   logic [2:0]       cause_q;
   logic [XLEN-1:0]  sr_rm0_q, sr_rm1_q, sr_rm2_q, redirect_pc_q;
   logic             priv_q, flush_q, stall_q, redirect_valid_q, busy_q;
   logic [CNT_W-1:0] count_q;

   logic             take_exc, take_iret;
   logic [2:0]       req_cause;
   logic [XLEN-1:0]  req_pc, req_addr;

   // Oldest instruction wins: MEM > ID > iret > IF.
   always_comb begin
      take_exc  = 1'b0;
      take_iret = 1'b0;
      req_cause = 3'd0;
      req_pc    = '0;
      req_addr  = '0;
      if (ctl.exc_mem_valid) begin
         take_exc  = 1'b1;
         req_cause = 3'd3;
         req_pc    = ctl.exc_mem_pc;
         req_addr  = ctl.exc_mem_addr;
      end else if (ctl.exc_id_valid) begin
         take_exc  = 1'b1;
         req_cause = 3'd2;
         req_pc    = ctl.exc_id_pc;
      end else if (ctl.iret_req) begin
         if (priv_q) begin
            take_iret = 1'b1;
         end else begin
            take_exc  = 1'b1;
            req_cause = 3'd4;
            req_pc    = ctl.exc_id_pc;
         end
      end else if (ctl.exc_if_valid) begin
         take_exc  = 1'b1;
         req_cause = 3'd1;
         req_pc    = ctl.exc_if_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         flush_cnt        <= '0;
         pc_q             <= '0;
         addr_q           <= '0;
         cause_q          <= '0;
         sr_rm0_q         <= '0;
         sr_rm1_q         <= '0;
         sr_rm2_q         <= '0;
         redirect_pc_q    <= '0;
         priv_q           <= 1'b1;
         flush_q          <= 1'b0;
         stall_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         count_q          <= '0;
      end else begin
         // Outputs describe the state being entered; rm writes default to 0.
         sr_rm0_q         <= '0;
         sr_rm1_q         <= '0;
         sr_rm2_q         <= '0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         stall_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         case (state)
            IDLE: begin
               if (take_exc) begin
                  state     <= FLUSH;
                  flush_cnt <= 4'(FLUSH_CYCLES - 1);
                  pc_q      <= req_pc;
                  addr_q    <= req_addr;
                  cause_q   <= req_cause;
                  flush_q   <= 1'b1;
                  stall_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end else if (take_iret) begin
                  state            <= IRET;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= ctl.rm0_in;
                  busy_q           <= 1'b1;
               end
            end
            FLUSH: begin
               flush_q <= 1'b1;
               stall_q <= 1'b1;
               busy_q  <= 1'b1;
               if (flush_cnt == 4'd0) begin
                  state    <= SAVE;
                  sr_rm0_q <= pc_q;
                  sr_rm1_q <= addr_q;
                  sr_rm2_q <= {{(XLEN-3){1'b0}}, cause_q};
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            SAVE: begin
               state            <= REDIRECT;
               stall_q          <= 1'b1;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= HANDLER_PC;
               busy_q           <= 1'b1;
               if (count_q != '1)
                  count_q <= count_q + CNT_W'(1);
            end
            REDIRECT: begin
               state  <= IDLE;
               priv_q <= 1'b1;
            end
            IRET: begin
               state  <= IDLE;
               priv_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ctl.sr_rm0         = sr_rm0_q;
   assign ctl.sr_rm1         = sr_rm1_q;
   assign ctl.sr_rm2         = sr_rm2_q;
   assign ctl.priv           = priv_q;
   assign ctl.flush          = flush_q;
   assign ctl.stall          = stall_q;
   assign ctl.redirect_valid = redirect_valid_q;
   assign ctl.redirect_pc    = redirect_pc_q;
   assign ctl.busy           = busy_q;
   assign ctl.exc_count      = count_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized requests
// checked cycle by cycle against a behavioural trap model.
module tb_exc_ctrl;
   localparam int          XLEN = 32;
   localparam logic [31:0] HPC  = 32'h0000_2000;
   localparam int          FC   = 2;
   localparam int          CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exc_ctrl_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

   exc_ctrl #(.XLEN(XLEN), .HANDLER_PC(HPC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   logic m_priv;
   int   m_count;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_reqs();
      bus.exc_if_valid  = 1'b0;
      bus.exc_if_pc     = '0;
      bus.exc_id_valid  = 1'b0;
      bus.exc_id_pc     = '0;
      bus.exc_mem_valid = 1'b0;
      bus.exc_mem_pc    = '0;
      bus.exc_mem_addr  = '0;
      bus.iret_req      = 1'b0;
   endtask

   // Flushed instructions keep shouting while the sequencer is busy.
   task automatic noise();
      bus.exc_if_valid  = 1'b1;
      bus.exc_if_pc     = $urandom;
      bus.exc_id_valid  = 1'b1;
      bus.exc_id_pc     = $urandom;
      bus.exc_mem_valid = 1'($urandom_range(0, 1));
      bus.exc_mem_pc    = $urandom;
      bus.exc_mem_addr  = $urandom;
      bus.iret_req      = 1'($urandom_range(0, 1));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "/idle_busy"}, bus.busy, 1'b0);
      chk({tag, "/idle_flush"}, bus.flush, 1'b0);
      chk({tag, "/idle_stall"}, bus.stall, 1'b0);
      chk({tag, "/idle_rv"}, bus.redirect_valid, 1'b0);
      chk({tag, "/idle_rm2"}, bus.sr_rm2, 32'd0);
      chk({tag, "/idle_priv"}, bus.priv, m_priv);
      chk({tag, "/idle_count"}, bus.exc_count, m_count[CW-1:0]);
   endtask

   // Called at a negedge in IDLE with requests already driven.
   task automatic step(input string tag, input bit noisy);
      int          e_cause;
      bit          is_iret;
      logic [31:0] e_pc, e_addr, e_rpc;
      e_cause = 0;
      is_iret = 1'b0;
      e_pc    = '0;
      e_addr  = '0;
      e_rpc   = bus.rm0_in;
      if (bus.exc_mem_valid) begin
         e_cause = 3; e_pc = bus.exc_mem_pc; e_addr = bus.exc_mem_addr;
      end else if (bus.exc_id_valid) begin
         e_cause = 2; e_pc = bus.exc_id_pc;
      end else if (bus.iret_req) begin
         if (m_priv) is_iret = 1'b1;
         else begin e_cause = 4; e_pc = bus.exc_id_pc; end
      end else if (bus.exc_if_valid) begin
         e_cause = 1; e_pc = bus.exc_if_pc;
      end

      @(negedge clk);
      if (is_iret) begin
         chk({tag, "/iret_busy"}, bus.busy, 1'b1);
         chk({tag, "/iret_flush"}, bus.flush, 1'b1);
         chk({tag, "/iret_stall"}, bus.stall, 1'b0);
         chk({tag, "/iret_rv"}, bus.redirect_valid, 1'b1);
         chk({tag, "/iret_rpc"}, bus.redirect_pc, e_rpc);
         chk({tag, "/iret_rm2"}, bus.sr_rm2, 32'd0);
         chk({tag, "/iret_priv"}, bus.priv, m_priv);
         if (noisy) noise(); else clear_reqs();
         m_priv = 1'b0;
         @(negedge clk);
      end else if (e_cause != 0) begin
         for (int c = 1; c <= FC + 2; c++) begin
            bit save, red;
            if (c > 1) @(negedge clk);
            save = (c == FC + 1);
            red  = (c == FC + 2);
            chk({tag, $sformatf("/c%0d_busy", c)}, bus.busy, 1'b1);
            chk({tag, $sformatf("/c%0d_flush", c)}, bus.flush, !red);
            chk({tag, $sformatf("/c%0d_stall", c)}, bus.stall, 1'b1);
            chk({tag, $sformatf("/c%0d_rv", c)}, bus.redirect_valid, red);
            if (red) chk({tag, "/handler_pc"}, bus.redirect_pc, HPC);
            chk({tag, $sformatf("/c%0d_rm0", c)}, bus.sr_rm0, save ? e_pc : 32'd0);
            chk({tag, $sformatf("/c%0d_rm1", c)}, bus.sr_rm1, save ? e_addr : 32'd0);
            chk({tag, $sformatf("/c%0d_rm2", c)}, bus.sr_rm2, save ? 32'(e_cause) : 32'd0);
            chk({tag, $sformatf("/c%0d_priv", c)}, bus.priv, m_priv);
            if (noisy) noise(); else clear_reqs();
         end
         m_priv  = 1'b1;
         m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
         @(negedge clk);
      end
      check_idle(tag);
      clear_reqs();
   endtask

   initial begin
      reset = 1'b1;
      clear_reqs();
      bus.rm0_in = '0;
      m_priv  = 1'b1;
      m_count = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state over five idle cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_idle($sformatf("reset_idle%0d", i));
      end

      // MEM data fault
      bus.exc_mem_valid = 1'b1;
      bus.exc_mem_pc    = 32'h0000_1040;
      bus.exc_mem_addr  = 32'h3FFF_FFFE;
      step("mem_fault", 1'b0);

      // All three at once, MEM wins, IF/ID ignored while busy
      bus.exc_if_valid  = 1'b1; bus.exc_if_pc  = 32'h0000_0100;
      bus.exc_id_valid  = 1'b1; bus.exc_id_pc  = 32'h0000_0200;
      bus.exc_mem_valid = 1'b1; bus.exc_mem_pc = 32'h0000_0300;
      bus.exc_mem_addr  = 32'hDEAD_BEE0;
      step("all_three", 1'b1);

      // Supervisor iret
      bus.rm0_in   = 32'h0000_1044;
      bus.iret_req = 1'b1;
      step("iret_sup", 1'b0);

      // User-mode iret is a privilege fault
      bus.iret_req  = 1'b1;
      bus.exc_id_pc = 32'h0000_0500;
      step("iret_user", 1'b0);

      // iret beats IF fault
      bus.iret_req     = 1'b1;
      bus.exc_if_valid = 1'b1;
      bus.exc_if_pc    = 32'h0000_0700;
      bus.rm0_in       = 32'h0000_0800;
      step("iret_vs_if", 1'b0);

      // Reset in the last FLUSH cycle aborts without a save
      bus.exc_id_valid = 1'b1;
      bus.exc_id_pc    = 32'h0000_0900;
      @(negedge clk);
      clear_reqs();
      chk("rst_flush1", bus.flush, 1'b1);
      @(negedge clk);
      chk("rst_flush2", bus.flush, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      m_priv  = 1'b1;
      m_count = 0;
      check_idle("rst_abort");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_idle($sformatf("rst_after%0d", i));
      end

      // Random request mixes against the model
      for (int i = 0; i < 30; i++) begin
         bus.exc_mem_valid = ($urandom_range(0, 3) == 0);
         bus.exc_mem_pc    = $urandom;
         bus.exc_mem_addr  = $urandom;
         bus.exc_id_valid  = ($urandom_range(0, 3) == 0);
         bus.exc_id_pc     = $urandom;
         bus.iret_req      = ($urandom_range(0, 2) == 0);
         bus.exc_if_valid  = ($urandom_range(0, 1) == 0);
         bus.exc_if_pc     = $urandom;
         bus.rm0_in        = $urandom;
         step($sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
      end

      // Drive the counter into saturation and beyond
      for (int i = 0; i < CMAX + 2; i++) begin
         bus.exc_if_valid = 1'b1;
         bus.exc_if_pc    = $urandom;
         step($sformatf("sat%0d", i), 1'b0);
      end
      chk("sat_final", bus.exc_count, CMAX[CW-1:0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/trap sequencer that owns the write side of the special-register file (rm0/rm1/rm2) and the privilege bit (rm3/PSW). It arbitrates exception requests from IF, ID and MEM, flushes the pipeline, commits the exception record in one save pulse, and redirects fetch to the OS handler. It also executes iret: restore PC from rm0 and drop privilege. Sits between the pipeline stages and the special-register block, in the same clock domain as the core.

Parameters:
XLEN, 32, datapath/PC width
HANDLER_PC, 32'h0000_2000, exception handler entry address
FLUSH_CYCLES, 2, cycles flush is held before save (1..15)
CNT_W, 16, width of saturating exception counter

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  reset, synchronous, active-high
exc_if_valid  in  1  fetch fault (ITLB miss / bad PC)
exc_if_pc  in  XLEN  PC of faulting fetch
exc_id_valid  in  1  illegal instruction
exc_id_pc  in  XLEN  PC of illegal instruction
exc_mem_valid  in  1  data fault (DTLB miss / unaligned)
exc_mem_pc  in  XLEN  PC of faulting load/store
exc_mem_addr  in  XLEN  faulting data address
iret_req  in  1  iret decoded in ID (uses exc_id_pc for privilege fault)
rm0_in  in  XLEN  current rm0 (saved return PC)
sr_rm0  out  XLEN  return PC to special regs
sr_rm1  out  XLEN  fault address to special regs
sr_rm2  out  XLEN  cause to special regs; nonzero = commit
priv  out  1  PSW: 1 = supervisor
flush  out  1  kill all in-flight instructions
stall  out  1  freeze PC/pipeline registers
redirect_valid  out  1  load redirect_pc into PC this cycle
redirect_pc  out  XLEN  new fetch address
busy  out  1  FSM not IDLE
exc_count  out  CNT_W  exceptions taken, saturating

Behaviour:
- Reset (sync, high): state IDLE; priv=1 (boot in supervisor); all other outputs 0; holding regs and exc_count 0. Reset in any state aborts the sequence next edge; no partial save is emitted after reset.
- States: IDLE, FLUSH, SAVE, REDIRECT, IRET.
- IDLE: request inputs are sampled only here. Priority: MEM > ID > iret > IF (oldest instruction first).
- Exception accepted: latch pc, addr (MEM: exc_mem_addr, else 0), cause; counter=FLUSH_CYCLES-1; go FLUSH.
- Cause codes: IF=1, ID illegal=2, MEM=3, privilege violation=4. Always nonzero.
- iret_req with priv=1, no MEM/ID exception: go IRET.
- iret_req with priv=0: treated as an exception with cause 4, pc=exc_id_pc, addr=0.
- FLUSH: flush=1, stall=1; counter decrements each cycle; at 0 go SAVE. Occupies exactly FLUSH_CYCLES cycles.
- SAVE (1 cycle): flush=1, stall=1, sr_rm0=latched pc, sr_rm1=latched addr, sr_rm2=latched cause; exc_count++ unless all-ones; go REDIRECT.
- sr_rm0/sr_rm1/sr_rm2 are 0 in every state other than SAVE. The special regs commit on nonzero rm2, so a nonzero value outside SAVE is a bug.
- REDIRECT (1 cycle): stall=1, redirect_valid=1, redirect_pc=HANDLER_PC, priv<=1; go IDLE.
- IRET (1 cycle): flush=1, redirect_valid=1, redirect_pc=rm0_in sampled this cycle, priv<=0; go IDLE. No rm writes.
- Exception latency: request in IDLE at edge N; redirect_valid high during cycle N+FLUSH_CYCLES+2; handler fetch follows.
- Requests arriving while busy=1 are ignored. They are the flushed instructions and re-raise after restart if still valid.
- Nested exception with priv=1 is taken normally; rm0-rm2 are overwritten.
- busy=1 in all non-IDLE states. flush, stall and redirect_valid are registered outputs decoded from the state, glitch-free.

Test Plan:
1. Reset, then idle 5 cycles -> priv=1; flush, stall, redirect_valid and sr_rm2 all 0; exc_count=0.
2. exc_mem_valid, pc=0x1040, addr=0x3FFF_FFFE; FLUSH_CYCLES=2 -> flush for 3 cycles; one SAVE cycle with sr_rm0=0x1040, sr_rm1=0x3FFF_FFFE, sr_rm2=3; redirect to 0x2000 at request+4; exc_count=1.
3. exc_if_valid, exc_id_valid and exc_mem_valid asserted together -> cause 3 saved (MEM wins); IF and ID re-asserted while busy are ignored; exactly one SAVE pulse.
4. priv=1, iret_req, rm0_in=0x1044 -> one IRET cycle, redirect_pc=0x1044, priv=0 next cycle, sr_rm2 stays 0.
5. priv=0, iret_req, exc_id_pc=0x500 -> privilege fault, sr_rm0=0x500, sr_rm2=4, priv=1 after REDIRECT.
6. Reset asserted during FLUSH, then released -> IDLE; sr_rm2 never nonzero; exc_count=0. Separately, force exc_count to all-ones and take one more exception -> exc_count stays all-ones.
